// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake and ALU operand/result bus shared by the issuer and the execution controller.
// The master modport issues instructions and computes ALU results; the slave modport is the controller.
interface alu_exec_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [1:0]       rd;
  logic [1:0]       rs1;
  logic [1:0]       rs2;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_s;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cout;
  logic             alu_neg;
  logic             alu_ovf;

  modport master (
    output in_valid, op, rd, rs1, rs2, imm,
    input  in_ready,
    input  alu_a, alu_b, alu_s, alu_cin,
    output alu_out, alu_cout, alu_neg, alu_ovf
  );

  modport slave (
    input  in_valid, op, rd, rs1, rs2, imm,
    output in_ready,
    output alu_a, alu_b, alu_s, alu_cin,
    input  alu_out, alu_cout, alu_neg, alu_ovf
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Three-cycle execution controller: accepts one instruction, drives an external ALU,
// then writes the result back to a 4-entry register file and updates status flags.
module alu_exec_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_ctrl_if.slave   bus,
  output logic             o_flag_c,
  output logic             o_flag_n,
  output logic             o_flag_z,
  output logic             o_flag_v,
  output logic             o_done,
  input  logic [1:0]       i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_INC = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_inReady;
  logic             w_done;
  logic             w_accept;
  logic [1:0]       w_sel;
  logic             w_cin;
  logic             w_aluZero;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [2:0]       r_op;
  logic [1:0]       r_rd;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [1:0]       r_aluS;
  logic             r_aluCin;
  logic             r_flagC;
  logic             r_flagN;
  logic             r_flagZ;
  logic             r_flagV;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_nextState = EXEC;
      EXEC:    w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_inReady = (r_state == IDLE);
    w_done    = (r_state == WB);
  end

  assign w_accept = bus.in_valid && w_inReady;

  // ADC/SBC take the carry flag as it stands at acceptance, not at execution.
  always_comb begin
    w_sel = 2'b11;
    w_cin = 1'b0;
    case (bus.op)
      OP_ADD:  begin w_sel = 2'b00; w_cin = 1'b0;    end
      OP_SUB:  begin w_sel = 2'b01; w_cin = 1'b1;    end
      OP_ADC:  begin w_sel = 2'b00; w_cin = r_flagC; end
      OP_SBC:  begin w_sel = 2'b01; w_cin = r_flagC; end
      OP_INC:  begin w_sel = 2'b10; w_cin = 1'b1;    end
      default: begin w_sel = 2'b11; w_cin = 1'b0;    end
    endcase
  end

  assign w_aluZero = (bus.alu_out == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_aluA   <= '0;
      r_aluB   <= '0;
      r_aluS   <= 2'b11;
      r_aluCin <= 1'b0;
      r_flagC  <= 1'b0;
      r_flagN  <= 1'b0;
      r_flagZ  <= 1'b0;
      r_flagV  <= 1'b0;
    end else if (w_accept) begin
      r_op     <= bus.op;
      r_rd     <= bus.rd;
      r_imm    <= bus.imm;
      r_aluA   <= r_regs[bus.rs1];
      r_aluB   <= r_regs[bus.rs2];
      r_aluS   <= w_sel;
      r_aluCin <= w_cin;
    end else if (r_state == EXEC) begin
      case (r_op)
        OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_INC: begin
          r_regs[r_rd] <= bus.alu_out;
          r_flagC      <= bus.alu_cout;
          r_flagN      <= bus.alu_neg;
          r_flagV      <= bus.alu_ovf;
          r_flagZ      <= w_aluZero;
        end
        OP_MOV: begin
          r_regs[r_rd] <= bus.alu_out;
          r_flagN      <= bus.alu_neg;
          r_flagZ      <= w_aluZero;
        end
        OP_LDI: begin
          r_regs[r_rd] <= r_imm;
          r_flagN      <= r_imm[WIDTH-1];
          r_flagZ      <= (r_imm == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = w_inReady;
  assign bus.alu_a    = r_aluA;
  assign bus.alu_b    = r_aluB;
  assign bus.alu_s    = r_aluS;
  assign bus.alu_cin  = r_aluCin;
  assign o_done       = w_done;
  assign o_flag_c     = r_flagC;
  assign o_flag_n     = r_flagN;
  assign o_flag_z     = r_flagZ;
  assign o_flag_v     = r_flagV;
  assign o_dbg_data   = r_regs[i_dbg_addr];

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width of operands, registers and result.
REQ-002 Parameter: NREGS, fixed 4, register-file depth; register index is 2 bits.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  instruction offered.
REQ-006 Port: in_ready  output  1  block can accept an instruction.
REQ-007 Port: op  input  3  opcode: 000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 INC, 101 MOV, 110 LDI, 111 NOP.
REQ-008 Port: rd, rs1, rs2  input  2 each  destination and source register indices.
REQ-009 Port: imm  input  WIDTH  immediate for LDI.
REQ-010 Port: alu_a, alu_b  output  WIDTH each  registered operands to the arithmetic ALU.
REQ-011 Port: alu_s  output  2  ALU select (00 a+b, 01 a+~b, 10/11 a+0).
REQ-012 Port: alu_cin  output  1  registered carry-in to the ALU.
REQ-013 Port: alu_out  input  WIDTH; alu_cout, alu_neg, alu_ovf  input  1 each  ALU results, combinational from alu_* outputs.
REQ-014 Port: flag_c, flag_n, flag_z, flag_v  output  1 each  registered status flags.
REQ-015 Port: done  output  1  one-cycle pulse when an instruction retires.
REQ-016 Port: dbg_addr  input  2; dbg_data  output  WIDTH  combinational register-file read.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, WB; in_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: instruction accepted on a rising edge where in_valid=1 and in_ready=1; op, rd, rs1, rs2, imm latched at that edge; IDLE->EXEC.
REQ-019 At acceptance, alu_a<=R[rs1], alu_b<=R[rs2], and alu_s/alu_cin per op: ADD 00/0, SUB 01/1, ADC 00/flag_c, SBC 01/flag_c, INC 10/1, MOV 11/0; LDI and NOP drive 11/0.
REQ-020 EXEC lasts exactly one cycle; at its closing edge result and flags captured; EXEC->WB.
REQ-021 Writeback: ADD..MOV write alu_out to R[rd]; LDI writes latched imm; NOP writes nothing.
REQ-022 Flags: ADD, SUB, ADC, SBC, INC update C=alu_cout, N=alu_neg, V=alu_ovf, Z=(alu_out==0).
REQ-023 MOV updates N, Z from alu_out and LDI updates N=imm[WIDTH-1], Z=(imm==0); both hold C, V; NOP holds all flags.
REQ-024 Carry on SUB/SBC is no-borrow polarity (C=1 when R[rs1]>=subtrahend).
REQ-025 All arithmetic modulo 2^WIDTH; wrap-around (e.g. 0xFF+1) produces 0x00 with C=1, no error.
REQ-026 WB lasts one cycle with done=1, then WB->IDLE; latency: accept at edge 0, done high in cycle after edge 2's predecessor, i.e. cycle 2; next accept possible at edge 3.
REQ-027 rd equal to rs1 or rs2 SHALL be legal; sources read at acceptance, destination written at end of EXEC.
REQ-028 dbg_data SHALL reflect the written value from the first cycle of WB onward.
REQ-029 in_valid while not in IDLE SHALL be ignored; instruction fields SHALL not be sampled outside acceptance.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, all registers R0..R3=0, all flags=0, done=0, alu_a=alu_b=0, alu_s=11, alu_cin=0, independent of clk.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-032 Reset asserted in EXEC or WB SHALL abort the instruction: no writeback, no done pulse.

Verification
REQ-033 LDI R1,0x7F; LDI R2,0x01; ADD R3,R1,R2 -> R3=0x80, N=1, V=1, C=0, Z=0; done one cycle per instruction.
REQ-034 LDI R0,0x05; SUB R1,R0,R0 -> R1=0x00, Z=1, C=1, N=0, V=0.
REQ-035 LDI R0,0xFF; INC R0,R0 -> R0=0x00, C=1, Z=1; then ADC R1,R1,R1 with R1=0 -> R1=0x01, C=0.
REQ-036 in_valid held high continuously -> acceptance every 3 cycles, in_ready low in EXEC/WB, no instruction lost or duplicated.
REQ-037 Assert rst_n low during EXEC of ADD R2 -> R2 stays 0, no done, flags 0, in_ready=1 after release.
REQ-038 NOP after SUB setting C=1 -> flags unchanged, no register changed, done pulses once.
